aes_kexp: RTL

Iterative AES key-expansion engine directly downstream of the key byte-splitter. It accepts the cipher key as Nk words of byte lanes and generates the full schedule of 4·(Nr+1) words at one word per clock into an internal buffer. It then serves any 128-bit round key by index to the round datapath. Key length is fixed at build time by the shared AES constants package.

---
 rtl/aes_kexp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/aes_kexp.sv
// Iterative AES key expansion: loads an Nk-word key, generates one schedule word
// per clock into a local buffer, then serves 128-bit round keys by index.

package aes_const;
  localparam int NK = 4;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
endpackage

// Combinational AES S-box: GF(2^8) inverse as a^254, followed by the affine map.
module aes_kexp_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_kexp
  import aes_const::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   key_in [0:4*NK-1],
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out,
  output logic         done
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] w [0:NW-1];
  logic [5:0]  idx;
  logic [7:0]  rcon;
  logic [2:0]  wrap;
  logic        load;
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_word;
  logic [5:0]  base;

  assign load = key_valid && key_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (load) next_state = ST_EXPAND;
      ST_EXPAND: if (idx == 6'(NW - 1)) next_state = ST_DONE;
      ST_DONE:   if (load) next_state = ST_EXPAND;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state != ST_EXPAND);
    done      = (state == ST_DONE);
  end

  // wrap tracks i mod Nk; zero marks the RotWord/SubWord/rcon step
  always_comb begin
    prev_word = w[idx - 6'd1];
    back_word = w[idx - 6'(NK)];
    sub_in    = (wrap == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (wrap == 3'd0)
      temp_word = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && wrap == 3'd4)
      temp_word = sub_out;
    else
      temp_word = prev_word;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_kexp_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NW; j++) w[j] <= 32'h0;
      idx  <= 6'd0;
      rcon <= 8'h01;
      wrap <= 3'd0;
    end else if (load) begin
      for (int j = 0; j < NK; j++)
        w[j] <= {key_in[4*j], key_in[4*j+1], key_in[4*j+2], key_in[4*j+3]};
      idx  <= 6'(NK);
      rcon <= 8'h01;
      wrap <= 3'd0;
    end else if (state == ST_EXPAND) begin
      w[idx] <= back_word ^ temp_word;
      idx    <= idx + 6'd1;
      wrap   <= (wrap == 3'(NK - 1)) ? 3'd0 : wrap + 3'd1;
      if (wrap == 3'd0)
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  assign base = {rk_addr, 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rk_out <= 128'h0;
    else if (rk_addr > 4'(NR))
      rk_out <= 128'h0;
    else
      rk_out <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

endmodule
